divider: RTL and testbench

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It is a sibling of the EX-stage multiplier and uses the same start/busy interface. The EX stage issues a one-cycle start with operands from the forwarding muxes. It stalls ID/EX and EX/MEM while busy is high, and captures result into EX/MEM on the first cycle busy is low.

---
 rtl/divider.sv | 135 +++++++++++++
 tb/tb_divider.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// rtl/divider.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional macro DIVIDER_EARLY_OUT_EN: fast path when |a| < |b|.
module divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] rem, quo, divisor, special_val_r;
    logic [CNT_W-1:0]  cnt;
    logic              rem_op, neg_q, neg_r, special_r;

    logic              accept, signed_op, a_neg, b_neg, b_zero, ovf, early, special;
    logic [DATA_W-1:0] a_mag, b_mag, special_val;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] trial;
    logic              trial_ok;
    logic [DATA_W-1:0] fixed_q, fixed_r;

    assign busy      = (state != IDLE);
    assign accept    = start & ~busy & funct3[2];
    assign signed_op = ~funct3[0];
    assign a_neg     = signed_op & a[DATA_W-1];
    assign b_neg     = signed_op & b[DATA_W-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign b_zero    = (b == '0);
    assign ovf       = signed_op & (a == MIN_VAL) & (b == '1);

`ifdef DIVIDER_EARLY_OUT_EN
    assign early = ~b_zero & (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    assign special = b_zero | ovf | early;

    // b=0 wins over overflow; the early-out case shares the "remainder = a" rule.
    always_comb begin
        special_val = '0;
        if (b_zero) begin
            special_val = funct3[1] ? a : '1;
        end else if (ovf) begin
            special_val = funct3[1] ? '0 : MIN_VAL;
        end else begin
            special_val = funct3[1] ? a : '0;
        end
    end

    // The shifted partial remainder can reach DATA_W+1 bits; its top bit alone means it fits.
    assign shifted  = {rem, quo[DATA_W-1]};
    assign trial_ok = shifted[DATA_W] | (shifted[DATA_W-1:0] >= divisor);
    assign trial    = shifted[DATA_W-1:0] - divisor;

    assign fixed_q = neg_q ? -quo : quo;
    assign fixed_r = neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? FIX : CALC;
            CALC: if (cnt == LAST_CNT) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem           <= '0;
            quo           <= '0;
            divisor       <= '0;
            special_val_r <= '0;
            cnt           <= '0;
            rem_op        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            special_r     <= 1'b0;
            result        <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        rem           <= '0;
                        quo           <= a_mag;
                        divisor       <= b_mag;
                        rem_op        <= funct3[1];
                        neg_q         <= a_neg ^ b_neg;
                        neg_r         <= a_neg;
                        special_r     <= special;
                        special_val_r <= special_val;
                    end
                end
                CALC: begin
                    rem <= trial_ok ? trial : shifted[DATA_W-1:0];
                    quo <= {quo[DATA_W-2:0], trial_ok};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    result <= special_r ? special_val_r : (rem_op ? fixed_r : fixed_q);
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed scoreboard bench for divider
module tb_divider;

    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;
    localparam logic [2:0] REMU = 3'b111;

`ifdef DIVIDER_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    divider #(.DATA_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .funct3(funct3),
        .a(a),
        .b(b),
        .result(result),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns 1 ns after the accept edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp);
        start  = 1'b1;
        funct3 = f;
        a      = x;
        b      = y;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // pulse_at > 0 drives a stray DIVU 9/3 start during that busy cycle.
    task automatic wait_done(input string tag, input int exp_lat, input int pulse_at);
        int lat;
        logic [31:0] e;
        lat = 0;
        @(negedge clk);
        while (busy === 1'b1 && lat < 200) begin
            lat++;
            if (lat == pulse_at) begin
                start  = 1'b1;
                funct3 = DIVU;
                a      = 32'd9;
                b      = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_result"}, result, e);
    endtask

    initial begin
        int seen;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        start  = 1'b1;
        funct3 = 3'b000;
        a      = 32'd5;
        b      = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("non_m_busy", {31'b0, busy}, 32'd0);
        check("non_m_done", {31'b0, done}, 32'd0);

        issue(DIVU, 32'd100, 32'd7, 32'd14);
        wait_done("divu_100_7", 33, 0);
        @(negedge clk);
        check("done_pulse_end", {31'b0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("result_hold", result, 32'd14);

        issue(REMU, 32'd100, 32'd7, 32'd2);
        wait_done("remu_100_7", 33, 0);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        wait_done("div_m7_2", 33, 0);
        issue(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        wait_done("rem_m7_2", 33, 0);
        issue(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        wait_done("div_7_m2", 33, 0);
        issue(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        wait_done("divu_max_1", 33, 0);
        issue(REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);
        wait_done("remu_wide", 33, 0);

        issue(DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        wait_done("div_by0", 1, 0);
        issue(REMU, 32'd5, 32'd0, 32'd5);
        wait_done("remu_by0", 1, 0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("div_ovf", 1, 0);
        issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_done("rem_ovf", 1, 0);

        issue(DIVU, 32'd100, 32'd7, 32'd14);
        wait_done("busy_ignore", 33, 10);
        issue(DIVU, 32'd9, 32'd3, 32'd3);
        check("b2b_done_low", {31'b0, done}, 32'd0);
        check("b2b_busy_high", {31'b0, busy}, 32'd1);
        wait_done("b2b_9_3", 33, 0);

        start  = 1'b1;
        funct3 = DIVU;
        a      = 32'd100;
        b      = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        issue(DIVU, 32'd20, 32'd4, 32'd5);
        wait_done("divu_20_4", 33, 0);

        issue(DIVU, 32'd3, 32'd10, 32'd0);
        wait_done("divu_small", EO_LAT, 0);
        issue(REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD);
        wait_done("rem_small_neg", EO_LAT, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
